// File: rtl/delta_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | delta_decoder_pkg                                                          |
// | Shared types and the shortest-path decode used by delta_decoder.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package delta_decoder_pkg;

   localparam int unsigned c_MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      NOREF = 2'd0,
      ARMED = 2'd1,
      FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic                   down;
      logic [c_MAX_WIDTH-1:0] delta;
      logic                   err;
   } decode_t;

   // Operands are zero-extended to c_MAX_WIDTH; width selects the modulus.
   function automatic decode_t decode(
      input logic [c_MAX_WIDTH-1:0] sample,
      input logic [c_MAX_WIDTH-1:0] ref_s,
      input int unsigned            width     = 8,
      input logic [c_MAX_WIDTH-1:0] max_delta = 127
   );
      logic [c_MAX_WIDTH-1:0] mask;
      logic [c_MAX_WIDTH-1:0] diff;
      decode_t                d;
      mask    = '1;
      mask    = mask >> (c_MAX_WIDTH - width);
      diff    = (sample - ref_s) & mask;
      d.down  = |(diff & (mask ^ (mask >> 1)));
      d.delta = d.down ? ((-diff) & mask) : diff;
      d.err   = (d.delta > max_delta);
      return d;
   endfunction

endpackage
`default_nettype wire

// File: rtl/delta_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | delta_decoder_if                                                           |
// | Sample input stream and decoded beat output stream of delta_decoder.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface delta_decoder_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ERR_CNT_W = 8
);
   logic                 clear_i;
   logic                 valid_i;
   logic                 ready_o;
   logic [WIDTH-1:0]     sample_i;
   logic                 valid_o;
   logic                 ready_i;
   logic                 down_o;
   logic [WIDTH-1:0]     delta_o;
   logic                 err_o;
   logic [ERR_CNT_W-1:0] err_cnt_o;

   modport slave (
      input  clear_i, valid_i, sample_i, ready_i,
      output ready_o, valid_o, down_o, delta_o, err_o, err_cnt_o
   );

   modport master (
      output clear_i, valid_i, sample_i, ready_i,
      input  ready_o, valid_o, down_o, delta_o, err_o, err_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/delta_decoder_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sat_counter                                                                |
// | Up counter that sticks at its all-ones value; synchronous clear.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sat_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count_o
);
   localparam logic [WIDTH-1:0] c_MAX = '1;

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != c_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count_o = r_count;
endmodule
`default_nettype wire

// File: rtl/delta_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | delta_decoder                                                              |
// | Recovers (down, delta) from successive samples of an up/down counter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module delta_decoder
   import delta_decoder_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_DELTA = 2**(WIDTH-1)-1,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   delta_decoder_if.slave   bus
);
   localparam logic [1:0] c_ST_NOREF = 2'(NOREF);
   localparam logic [1:0] c_ST_ARMED = 2'(ARMED);
   localparam logic [1:0] c_ST_FULL  = 2'(FULL);

   logic [1:0]             r_state;
   logic [WIDTH-1:0]       r_ref;
   logic                   r_down;
   logic [WIDTH-1:0]       r_delta;
   logic                   r_err;

   logic                   w_ready;
   logic                   w_accept;
   logic                   w_load;
   logic [c_MAX_WIDTH-1:0] w_sample_ext;
   logic [c_MAX_WIDTH-1:0] w_ref_ext;
   decode_t                w_dec;

   // ready depends only on clear/ready_i and state, never on valid_i
   assign w_ready  = !bus.clear_i && ((r_state != c_ST_FULL) || bus.ready_i);
   assign w_accept = bus.valid_i && w_ready;
   assign w_load   = w_accept && (r_state != c_ST_NOREF);

   assign w_sample_ext = c_MAX_WIDTH'(bus.sample_i);
   assign w_ref_ext    = c_MAX_WIDTH'(r_ref);
   assign w_dec        = decode(w_sample_ext, w_ref_ext, WIDTH, MAX_DELTA);

   generate
      if (WIDTH < c_MAX_WIDTH) begin : g_unused_hi
         logic w_unused_delta_hi;
         assign w_unused_delta_hi = ^w_dec.delta[c_MAX_WIDTH-1:WIDTH];
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= c_ST_NOREF;
         r_ref   <= '0;
         r_down  <= 1'b0;
         r_delta <= '0;
         r_err   <= 1'b0;
      end else if (bus.clear_i) begin
         r_state <= c_ST_NOREF;
         r_ref   <= '0;
         r_down  <= 1'b0;
         r_delta <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_ref <= bus.sample_i;
         if (r_state == c_ST_NOREF) begin
            r_state <= c_ST_ARMED;
         end else begin
            r_state <= c_ST_FULL;
            r_down  <= w_dec.down;
            r_delta <= w_dec.delta[WIDTH-1:0];
            r_err   <= w_dec.err;
         end
      end else if ((r_state == c_ST_FULL) && bus.ready_i) begin
         r_state <= c_ST_ARMED;
      end
   end

   sat_counter #(
      .WIDTH (ERR_CNT_W)
   ) u_err_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr     (bus.clear_i),
      .inc     (w_load && w_dec.err),
      .count_o (bus.err_cnt_o)
   );

   assign bus.ready_o = w_ready;
   assign bus.valid_o = (r_state == c_ST_FULL);
   assign bus.down_o  = r_down;
   assign bus.delta_o = r_delta;
   assign bus.err_o   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_delta_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_delta_decoder                                                           |
// | Directed plus randomized stimulus against an arithmetic reference model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_delta_decoder;
   localparam int c_W    = 8;
   localparam int c_MOD  = 256;
   localparam int c_MAXD = 16;
   localparam int c_CMAX = 255;

   logic clk;
   logic rst_n;

   delta_decoder_if #(.WIDTH(c_W), .ERR_CNT_W(8)) bif ();

   delta_decoder #(
      .WIDTH     (c_W),
      .MAX_DELTA (c_MAXD),
      .ERR_CNT_W (8)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit         m_has_ref;
   int         m_ref;
   bit         m_pend;
   logic [9:0] m_beat;
   int         m_cnt;
   logic [9:0] got_q[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Beat packed as {down, delta[7:0], err}; shortest path modulo 256.
   function automatic logic [9:0] ref_beat(input int s, input int r);
      int d;
      int mag;
      bit dn;
      d   = (s - r + c_MOD) % c_MOD;
      dn  = (d >= c_MOD / 2);
      mag = dn ? (c_MOD - d) : d;
      return {dn, 8'(mag), (mag > c_MAXD)};
   endfunction

   function automatic logic [9:0] lit(input bit dn, input int mag, input bit e);
      return {dn, 8'(mag), e};
   endfunction

   always @(negedge clk) begin
      bit exp_ready;
      if (!rst_n) begin
         m_has_ref = 0; m_ref = 0; m_pend = 0; m_cnt = 0;
         chk("rst_valid", bif.valid_o, 0);
         chk("rst_fields", {bif.down_o, bif.delta_o, bif.err_o}, 0);
         chk("rst_errcnt", bif.err_cnt_o, 0);
      end else begin
         exp_ready = !bif.clear_i && (!m_pend || bif.ready_i);
         chk("ready_o", bif.ready_o, exp_ready);
         chk("valid_o", bif.valid_o, m_pend);
         if (m_pend) chk("beat", {bif.down_o, bif.delta_o, bif.err_o}, m_beat);
         chk("err_cnt", bif.err_cnt_o, m_cnt);
         if (bif.clear_i) begin
            m_has_ref = 0; m_ref = 0; m_pend = 0; m_cnt = 0;
         end else begin
            if (bif.valid_o && bif.ready_i) got_q.push_back({bif.down_o, bif.delta_o, bif.err_o});
            if (m_pend && bif.ready_i) m_pend = 0;
            if (bif.valid_i && exp_ready) begin
               if (m_has_ref) begin
                  m_beat = ref_beat(int'(bif.sample_i), m_ref);
                  m_pend = 1;
                  if (m_beat[0] && m_cnt < c_CMAX) m_cnt++;
               end
               m_has_ref = 1;
               m_ref     = int'(bif.sample_i);
            end
         end
      end
   end

   task automatic wait_accept();
      bit done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bif.ready_o) done = 1;
      end
      n_checks++;
      if (!done) begin
         n_errors++;
         $display("FAIL accept_timeout: got no ready_o expected ready_o=1 within 50 cycles");
      end
      @(posedge clk); #1;
      bif.valid_i = 1'b0;
   endtask

   task automatic send(input int s);
      bif.valid_i  = 1'b1;
      bif.sample_i = 8'(s);
      wait_accept();
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_clear();
      bif.clear_i = 1'b1;
      @(posedge clk); #1;
      bif.clear_i = 1'b0;
   endtask

   task automatic chk_beats(input string name, input int base, input logic [9:0] exp[$]);
      chk({name, "_count"}, got_q.size() - base, exp.size());
      foreach (exp[i]) begin
         if (base + i < got_q.size()) chk(name, got_q[base + i], exp[i]);
      end
   endtask

   initial begin
      int base;
      int prev;
      logic [9:0] exp[$];
      rst_n = 1'b0;
      bif.clear_i = 0; bif.valid_i = 0; bif.sample_i = '0; bif.ready_i = 1'b1;
      idle(2);
      rst_n = 1'b1;
      idle(1);

      // first sample only arms
      base = got_q.size();
      send(10); send(13); idle(3);
      exp = '{lit(0, 3, 0)};
      chk_beats("first", base, exp);

      // down decode and wrap
      pulse_clear();
      base = got_q.size();
      send(20); send(14); send(250); send(4); idle(3);
      exp = '{lit(1, 6, 0), lit(1, 20, 1), lit(0, 10, 0)};
      chk_beats("wrap", base, exp);
      send(4); idle(2);
      chk("wrap_rev", got_q[got_q.size()-1], lit(0, 0, 0));
      pulse_clear();
      send(4); send(250); idle(2);
      chk("wrap_down", got_q[got_q.size()-1], lit(1, 10, 0));

      // range error and saturation
      pulse_clear();
      base = got_q.size();
      send(0); send(100); send(100); idle(3);
      exp = '{lit(0, 100, 1), lit(0, 0, 0)};
      chk_beats("range", base, exp);
      chk("range_cnt", bif.err_cnt_o, 1);
      for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 0 : 100);
      idle(3);
      chk("sat_cnt", bif.err_cnt_o, 255);

      // backpressure
      pulse_clear();
      base = got_q.size();
      send(50);
      bif.ready_i = 1'b0;
      send(60);
      repeat (5) begin
         @(negedge clk);
         chk("bp_ready", bif.ready_o, 0);
         chk("bp_hold", {bif.valid_o, bif.down_o, bif.delta_o, bif.err_o}, {1'b1, lit(0, 10, 0)});
      end
      @(posedge clk); #1;
      bif.valid_i = 1'b1; bif.sample_i = 8'd55;
      idle(2);
      bif.ready_i = 1'b1;
      wait_accept();
      idle(3);
      exp = '{lit(0, 10, 0), lit(1, 5, 0)};
      chk_beats("bp", base, exp);

      // clear while FULL with a sample on the input
      bif.ready_i = 1'b0;
      send(30);
      bif.valid_i = 1'b1; bif.sample_i = 8'd77; bif.clear_i = 1'b1;
      @(posedge clk); #1;
      bif.clear_i = 1'b0; bif.valid_i = 1'b0;
      chk("clr_valid", bif.valid_o, 0);
      chk("clr_cnt", bif.err_cnt_o, 0);
      bif.ready_i = 1'b1;
      base = got_q.size();
      send(7); send(9); idle(3);
      exp = '{lit(0, 2, 0)};
      chk_beats("clr", base, exp);

      // randomized traffic, boundary-weighted differences
      prev = 0;
      for (int i = 0; i < 600; i++) begin
         int pick;
         case ($urandom_range(0, 5))
            0: pick = 0;
            1: pick = c_MAXD;
            2: pick = c_MAXD + 1;
            3: pick = c_MOD - c_MAXD;
            4: pick = c_MOD / 2;
            default: pick = int'($urandom_range(0, c_MOD - 1));
         endcase
         prev = (prev + pick) % c_MOD;
         bif.sample_i = 8'(prev);
         bif.valid_i  = ($urandom_range(0, 3) != 0);
         bif.ready_i  = ($urandom_range(0, 3) != 0);
         bif.clear_i  = ($urandom_range(0, 63) == 0);
         idle(1);
      end
      bif.valid_i = 0; bif.clear_i = 0; bif.ready_i = 1'b1;
      idle(3);

      // asynchronous reset with an error beat pending
      pulse_clear();
      send(0);
      bif.ready_i = 1'b0;
      send(100);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", bif.valid_o, 0);
      chk("arst_fields", {bif.down_o, bif.delta_o, bif.err_o}, 0);
      chk("arst_cnt", bif.err_cnt_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bif.ready_i = 1'b1;
      base = got_q.size();
      send(5); send(8); idle(3);
      exp = '{lit(0, 3, 0)};
      chk_beats("arst", base, exp);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
